// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - multi-cycle ALU: single-cycle simple ops, iterative multiply/divide.
// Optional signed divide on op 1111 when ITER_ALU_SIGNED_DIV_EN is defined.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r2,
  output logic             of,
  output logic             cf,
  output logic             eq
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_SLL = 4'h0, OP_SRA = 4'h1, OP_SRL = 4'h2, OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIVU = 4'h4, OP_ADD = 4'h5, OP_SUB = 4'h6, OP_AND = 4'h7;
  localparam logic [3:0] OP_OR = 4'h8, OP_XOR = 4'h9, OP_NOR = 4'hA, OP_SLT = 4'hB;
  localparam logic [3:0] OP_SLTU = 4'hC, OP_SLLV = 4'hD, OP_MULU = 4'hE, OP_DIVX = 4'hF;

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIN} state_t;
  state_t state, state_nx;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q, a, hi, lo;
  logic [SHW-1:0]   cnt;
  logic             neg_q;

  logic accept, in_long, q_mul, q_smul, q_sdiv, sgn;
  assign ready   = (state == IDLE);
  assign accept  = start & ready & ~flush;
  assign in_long = (op == OP_MUL) | (op == OP_MULU) | (op == OP_DIVU) | (op == OP_DIVX);
  assign q_mul   = (op_q == OP_MUL) | (op_q == OP_MULU);
  assign q_smul  = (op_q == OP_MUL);
`ifdef ITER_ALU_SIGNED_DIV_EN
  logic neg_r;
  assign q_sdiv = (op_q == OP_DIVX);
`else
  assign q_sdiv = 1'b0;
`endif
  assign sgn = q_smul | q_sdiv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) state_nx = IDLE;
    else begin
      case (state)
        IDLE: if (accept && in_long) state_nx = PREP;
        PREP: state_nx = ITER;
        ITER: if (cnt == '0) state_nx = FIN;
        FIN:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Single-cycle results, computed from the live inputs at the accept edge.
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] s_r;
  logic             s_of, s_cf;
  always_comb begin
    add_w = {1'b0, x} + {1'b0, y};
    sub_w = {1'b0, x} - {1'b0, y};
    s_r   = '0;
    s_of  = 1'b0;
    s_cf  = 1'b0;
    case (op)
      OP_SLL:  s_r = x << y[SHW-1:0];
      OP_SRA:  s_r = $signed(x) >>> y[SHW-1:0];
      OP_SRL:  s_r = x >> y[SHW-1:0];
      OP_ADD: begin
        s_r  = add_w[WIDTH-1:0];
        s_cf = add_w[WIDTH];
        s_of = (x[WIDTH-1] == y[WIDTH-1]) && (add_w[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        s_r  = sub_w[WIDTH-1:0];
        s_cf = sub_w[WIDTH];
        s_of = (x[WIDTH-1] != y[WIDTH-1]) && (sub_w[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND:  s_r = x & y;
      OP_OR:   s_r = x | y;
      OP_XOR:  s_r = x ^ y;
      OP_NOR:  s_r = ~(x | y);
      OP_SLT:  s_r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: s_r = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_SLLV: s_r = y << x[SHW-1:0];
      default: s_r = '0;
    endcase
  end

  // One step of shift-add multiply (hi:lo shifts right) or restoring divide (hi = partial remainder).
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
  assign div_sh  = {hi, lo[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, a};
  assign div_sub = div_sh[WIDTH-1:0] - a;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               fin_of;
  always_comb begin
    prod   = {hi, lo};
    quo    = lo;
    rem    = hi;
    fin_of = 1'b0;
    if (q_smul && neg_q) prod = -prod;
`ifdef ITER_ALU_SIGNED_DIV_EN
    if (q_sdiv && neg_q) quo = -lo;
    if (q_sdiv && neg_r) rem = -hi;
    fin_of = q_sdiv && (x_q == {1'b1, {(WIDTH-1){1'b0}}}) && (y_q == '1);
`endif
    if (y_q == '0) begin
      quo = '1;
      rem = x_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0; r <= '0; r2 <= '0; of <= 1'b0; cf <= 1'b0; eq <= 1'b0;
      op_q <= '0; x_q <= '0; y_q <= '0; a <= '0; hi <= '0; lo <= '0;
      cnt <= '0; neg_q <= 1'b0;
`ifdef ITER_ALU_SIGNED_DIV_EN
      neg_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q <= op;
          x_q  <= x;
          y_q  <= y;
          if (!in_long) begin
            r    <= s_r;
            r2   <= '0;
            of   <= s_of;
            cf   <= s_cf;
            eq   <= (x == y);
            done <= 1'b1;
          end
        end
        PREP: begin
          lo    <= (sgn && x_q[WIDTH-1]) ? -x_q : x_q;
          a     <= (sgn && y_q[WIDTH-1]) ? -y_q : y_q;
          hi    <= '0;
          cnt   <= SHW'(WIDTH-1);
          neg_q <= sgn && (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
`ifdef ITER_ALU_SIGNED_DIV_EN
          neg_r <= q_sdiv && x_q[WIDTH-1];
`endif
        end
        ITER: begin
          cnt <= cnt - SHW'(1);
          if (q_mul) begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end else begin
            hi <= div_ge ? div_sub : div_sh[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], div_ge};
          end
        end
        FIN: if (!flush) begin
          r    <= q_mul ? prod[WIDTH-1:0] : quo;
          r2   <= q_mul ? prod[2*WIDTH-1:WIDTH] : rem;
          of   <= fin_of;
          cf   <= 1'b0;
          eq   <= (x_q == y_q);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - scoreboard bench for iter_alu with a randomized arithmetic reference model.
module tb_iter_alu;
  localparam int W = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [3:0] op = '0;
  logic [W-1:0] x = '0, y = '0;
  logic ready, done, of, cf, eq;
  logic [W-1:0] r, r2;

  iter_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op), .x(x), .y(y),
    .ready(ready), .done(done), .r(r), .r2(r2), .of(of), .cf(cf), .eq(eq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r, r2;
    logic of, cf, eq;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int cyc = 0, errors = 0, checks = 0;
  logic [31:0] last_r = '0, last_r2 = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic bit is_long(input logic [3:0] o);
    return (o == 4'h3) || (o == 4'h4) || (o == 4'hE) || (o == 4'hF);
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sv;
    logic [63:0] p;
    int sh;
    sh = int'(b[4:0]);
    e.r = '0; e.r2 = '0; e.of = 1'b0; e.cf = 1'b0; e.eq = (a == b); e.cyc = 0;
    case (o)
      4'h0: e.r = a << sh;
      4'h1: e.r = $signed(a) >>> sh;
      4'h2: e.r = a >> sh;
      4'h3: begin
        p = longint'($signed(a)) * longint'($signed(b));
        e.r = p[31:0]; e.r2 = p[63:32];
      end
      4'h5: begin
        e.r  = a + b;
        e.cf = (longint'(a) + longint'(b)) > longint'(32'hFFFF_FFFF);
        sv   = longint'($signed(a)) + longint'($signed(b));
        e.of = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'h6: begin
        e.r  = a - b;
        e.cf = a < b;
        sv   = longint'($signed(a)) - longint'($signed(b));
        e.of = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'h7: e.r = a & b;
      4'h8: e.r = a | b;
      4'h9: e.r = a ^ b;
      4'hA: e.r = ~(a | b);
      4'hB: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC: e.r = (a < b) ? 32'd1 : 32'd0;
      4'hD: e.r = b << int'(a[4:0]);
      4'hE: begin
        p = {32'd0, a} * {32'd0, b};
        e.r = p[31:0]; e.r2 = p[63:32];
      end
`ifdef ITER_ALU_SIGNED_DIV_EN
      4'hF: begin
        if (b == 0) begin
          e.r = '1; e.r2 = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.r = a; e.r2 = '0; e.of = 1'b1;
        end else begin
          e.r = $signed(a) / $signed(b); e.r2 = $signed(a) % $signed(b);
        end
      end
`endif
      default: begin
        if (b == 0) begin
          e.r = '1; e.r2 = a;
        end else begin
          e.r = a / b; e.r2 = a % b;
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) chk("spurious_done", 64'd1, 64'd0);
      else begin
        me = sbq.pop_front();
        chk("r", r, me.r);
        chk("r2", r2, me.r2);
        chk("of", of, me.of);
        chk("cf", cf, me.cf);
        chk("eq", eq, me.eq);
        chk("done_cycle", cyc, me.cyc);
        last_r  = me.r;
        last_r2 = me.r2;
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t e;
    int g = 0;
    while (ready !== 1'b1 && g < 100) begin
      @(posedge clk); #1; g++;
    end
    if (ready !== 1'b1) begin
      chk("ready_timeout", ready, 1'b1);
      return;
    end
    op = o; x = a; y = b; start = 1'b1;
    e = model(o, a, b);
    @(posedge clk); #1;
    start = 1'b0;
    e.cyc = cyc + (is_long(o) ? W + 2 : 0);
    if (track) sbq.push_back(e);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sbq.size() != 0 && g < 200) begin
      @(posedge clk); #1; g++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [3:0] o;
    #2;
    chk("rst_ready", ready, 1'b1);
    chk("rst_outs", {done, of, cf, eq, r, r2}, '0);
    @(posedge clk); #1; rst_n = 1'b1;

    // asynchronous reset in the middle of a multiply
    issue(4'h3, 32'hFFFF_FFFE, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_ready", ready, 1'b1);
    chk("async_rst_outs", {done, of, cf, eq, r, r2}, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    last_r = '0; last_r2 = '0;

    issue(4'h5, 32'd5, 32'd7, 1'b1);
    issue(4'h5, 32'h7FFF_FFFF, 32'd1, 1'b1);
    issue(4'h6, 32'd1, 32'd2, 1'b1);
    issue(4'h3, 32'hFFFF_FFFE, 32'd3, 1'b1);
    issue(4'hE, 32'hFFFF_FFFE, 32'd3, 1'b1);
    issue(4'h4, 32'd100, 32'd7, 1'b1);
    issue(4'h4, 32'd9, 32'd0, 1'b1);
    issue(4'hF, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(4'hF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(4'h1, 32'h8000_0010, 32'h0000_0024, 1'b1);
    issue(4'hD, 32'h0000_0023, 32'd1, 1'b1);
    wait_drain();

    // flush of an in-flight multiply; a start while busy is ignored
    issue(4'h5, 32'd3, 32'd4, 1'b1);
    wait_drain();
    issue(4'h3, 32'h1234_5678, 32'h0BAD_F00D, 1'b0);
    repeat (4) @(posedge clk);
    #1; op = 4'h5; x = 32'd1; y = 32'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_ready", ready, 1'b1);
    chk("flush_r", r, last_r);
    chk("flush_r2", r2, last_r2);
    chk("flush_done", done, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    // flush has priority over a start in IDLE
    op = 4'h5; x = 32'd2; y = 32'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    chk("flush_start_done", done, 1'b0);
    chk("flush_start_r", r, last_r);
    issue(4'h0, 32'd1, 32'h21, 1'b1);

    for (int i = 0; i < 80; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = '1;
        2: a = 32'h8000_0000;
        3: begin a = 32'h8000_0000; b = '1; end
        4: begin a = $urandom_range(0, 300); b = $urandom_range(0, 20); end
        5: b = a;
        default: ;
      endcase
      issue(o, a, b, 1'b1);
    end
    wait_drain();
    chk("queue_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Multi-cycle, parametrised successor to the datapath's single-cycle ALU. Sits in the EX stage of the streamline CPU.
- Simple ops (shift, add/sub, logic, compare) complete in 1 cycle.
- Multiply and divide use an iterative shift-add / restoring-divide engine, one bit per cycle. This replaces the combinational `*`, `/` and `%`.
- start/ready/done handshake lets the pipeline stall while busy. Adds unsigned multiply, defined divide-by-zero behaviour and a flush.

Parameters:
- WIDTH, 32, operand/result width in bits (≥8, power of 2).
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted on a rising edge when start=1 and ready=1.
- flush  in  1  synchronous abort of an in-flight op.
- op  in  4  operation code, sampled at accept.
- x  in  WIDTH  operand X, sampled at accept.
- y  in  WIDTH  operand Y, sampled at accept.
- ready  out  1  1 when idle and able to accept.
- done  out  1  one-cycle pulse; r/r2/flags valid from this cycle.
- r  out  WIDTH  primary result.
- r2  out  WIDTH  secondary result: product high half or remainder.
- of  out  1  signed overflow.
- cf  out  1  carry/borrow.
- eq  out  1  X==Y.

Behaviour:
- Reset: state IDLE; ready=1; done=0; r, r2, of, cf, eq = 0; iteration counter = 0.
- Op codes:
  - 0000 SLL: r = X<<Y[SHW-1:0]
  - 0001 SRA: arithmetic right shift of X by Y[SHW-1:0]
  - 0010 SRL: logical right shift of X by Y[SHW-1:0]
  - 0011 MUL signed: {r2,r} = X*Y, 2·WIDTH result
  - 0100 DIVU: r = X/Y, r2 = X%Y
  - 0101 ADD
  - 0110 SUB
  - 0111 AND
  - 1000 OR
  - 1001 XOR
  - 1010 NOR
  - 1011 SLT signed
  - 1100 SLTU
  - 1101 SLLV: r = Y<<X[SHW-1:0]
  - 1110 MULU: unsigned {r2,r} = X*Y
  - 1111: see Optional Feature
- Shift amounts always use the low SHW bits only.
- Flags:
  - eq is computed on every op, from the accepted operands.
  - ADD: cf = carry out of bit WIDTH-1; of = 1 when X and Y have equal signs and r's sign differs.
  - SUB: cf = 1 when X<Y unsigned (borrow); of = 1 when X and Y have different signs and r's sign differs from X.
  - All other ops: of = cf = 0.
  - Simple ops: r2 = 0.
- States: IDLE, PREP, ITER, FIN.
  - IDLE + accept of a simple op: r, r2 and flags are registered at the accept edge; done=1 in the next cycle; state stays IDLE. Latency 1; back-to-back accepts give one result per cycle.
  - IDLE + accept of a mul/div op: go to PREP; ready=0. PREP latches magnitudes and result sign for signed ops, and clears the accumulator.
  - PREP → ITER: counter = WIDTH-1. ITER processes one bit per cycle and decrements the counter; at 0 go to FIN.
  - FIN: applies sign correction, writes r/r2, pulses done, returns to IDLE.
  - Mul/div latency: done high WIDTH+2 cycles after the accept edge. ready returns to 1 in the same cycle as done, so a new start may be accepted then.
- Divide by zero (any divide op): r = all ones, r2 = X. Normal latency, no flag.
- Output hold: r, r2 and flags hold their last values between done pulses and while busy. done is never asserted without an accepted op.
- flush: when 1 at an edge, state goes to IDLE, no done is generated, outputs are unchanged. A flush coinciding with a start while in IDLE has priority: the start is dropped.
- start while ready=0 is ignored; it is not queued.
- rst_n low mid-operation: immediate return to the reset values, asynchronously.

Optional Feature:
- Macro ITER_ALU_SIGNED_DIV_EN.
- Defined: op 1111 = signed divide.
  - Quotient truncates toward zero; remainder takes the sign of X.
  - Special case -2^(WIDTH-1) / -1: r = -2^(WIDTH-1), r2 = 0, of = 1.
  - Latency WIDTH+2.
- Undefined: op 1111 decodes exactly as 0100 DIVU, and the sign-handling logic for division is not built.

Test Plan:
- Reset with rst_n=0 mid-ITER of a MUL → all outputs 0 and ready=1 asynchronously; after release, ADD x=5, y=7 → done in the next cycle, r=12, cf=0, of=0, eq=0.
- ADD x=0x7FFFFFFF, y=1 → r=0x80000000, of=1, cf=0. SUB x=1, y=2 → r=0xFFFFFFFF, cf=1, of=0.
- MUL x=0xFFFFFFFE (-2), y=3 → done exactly 34 cycles after accept; r=0xFFFFFFFA, r2=0xFFFFFFFF. MULU with the same operands → r=0xFFFFFFFA, r2=0x00000002.
- DIVU x=100, y=7 → r=14, r2=2 at cycle 34. DIVU x=9, y=0 → r=0xFFFFFFFF, r2=9.
- MUL in flight with start pulsed at cycle 5 and flush at cycle 10 → no done; ready=1 from cycle 11; r/r2 keep their previous values. A back-to-back SLL x=1, y=0x21 → r=2.
- With ITER_ALU_SIGNED_DIV_EN: op 1111, x=-7, y=2 → r=-3, r2=-1; x=0x80000000, y=-1 → r=0x80000000, r2=0, of=1. Without the macro: op 1111, x=-7, y=2 → r=0x7FFFFFFC, r2=1.
